execute_stage: RTL and testbench

// Execute stage of the 5-stage RV32I pipeline: ID/EX register, operand forwarding, ALU

---
 rtl/execute_stage.sv | 209 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execute_stage: RV32I ID/EX register, operand forwarding, ALU, branch/jal
// resolution and EX/MEM register. Optional macro EX_FORWARD_EN. Rev 1.0
// ----------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_hold,
  input  logic            id_flush,
  input  logic            id_valid,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [3:0]      id_alu_control,
  input  logic [2:0]      id_funct3,
  input  logic [1:0]      id_result_src,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            exm_valid,
  output logic            exm_reg_write,
  output logic            exm_mem_write,
  output logic [1:0]      exm_result_src,
  output logic [XLEN-1:0] exm_alu_result,
  output logic [XLEN-1:0] exm_write_data,
  output logic [XLEN-1:0] exm_pc_plus4,
  output logic [RA_W-1:0] exm_rd
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [1:0]      result_src;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } idex_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  idex_t           idex;
  idex_t           id_next;
  logic [XLEN-1:0] op_rs1;
  logic [XLEN-1:0] op_rs2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_y;
  logic [4:0]      shamt;
  logic            cond;
  logic [XLEN-1:0] pc_plus4;

  always_comb begin
    id_next             = '0;
    id_next.valid       = id_valid;
    id_next.reg_write   = id_reg_write;
    id_next.mem_write   = id_mem_write;
    id_next.alu_src     = id_alu_src;
    id_next.branch      = id_branch;
    id_next.jump        = id_jump;
    id_next.alu_control = id_alu_control;
    id_next.funct3      = id_funct3;
    id_next.result_src  = id_result_src;
    id_next.pc          = id_pc;
    id_next.rs1_data    = id_rs1_data;
    id_next.rs2_data    = id_rs2_data;
    id_next.imm         = id_imm;
    id_next.rs1         = id_rs1;
    id_next.rs2         = id_rs2;
    id_next.rd          = id_rd;
  end

  // A flush only bubbles ID/EX; EX/MEM still captures the instruction in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex <= '0;
    end else if (!ex_hold) begin
      if (id_flush) begin
        idex <= '0;
      end else begin
        idex <= id_next;
      end
    end
  end

`ifdef EX_FORWARD_EN
  // Only ALU-result producers in MEM can forward; loads are resolved by a stall.
  always_comb begin
    op_rs1 = idex.rs1_data;
    if (idex.rs1 != '0) begin
      if (exm_valid && exm_reg_write && (exm_rd == idex.rs1) && (exm_result_src == 2'b00)) begin
        op_rs1 = exm_alu_result;
      end else if (wb_reg_write && (wb_rd == idex.rs1)) begin
        op_rs1 = wb_result;
      end
    end
  end

  always_comb begin
    op_rs2 = idex.rs2_data;
    if (idex.rs2 != '0) begin
      if (exm_valid && exm_reg_write && (exm_rd == idex.rs2) && (exm_result_src == 2'b00)) begin
        op_rs2 = exm_alu_result;
      end else if (wb_reg_write && (wb_rd == idex.rs2)) begin
        op_rs2 = wb_result;
      end
    end
  end
`else
  assign op_rs1 = idex.rs1_data;
  assign op_rs2 = idex.rs2_data;

  wire unused_fwd = &{1'b0, wb_reg_write, wb_rd, wb_result, idex.rs1, idex.rs2};
`endif

  assign op_b  = idex.alu_src ? idex.imm : op_rs2;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_y = '0;
    case (idex.alu_control)
      ALU_ADD:  alu_y = op_rs1 + op_b;
      ALU_SUB:  alu_y = op_rs1 - op_b;
      ALU_SLL:  alu_y = op_rs1 << shamt;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(op_rs1) < $signed(op_b))};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (op_rs1 < op_b)};
      ALU_XOR:  alu_y = op_rs1 ^ op_b;
      ALU_SRL:  alu_y = op_rs1 >> shamt;
      ALU_SRA:  alu_y = $signed(op_rs1) >>> shamt;
      ALU_OR:   alu_y = op_rs1 | op_b;
      ALU_AND:  alu_y = op_rs1 & op_b;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (idex.funct3)
      3'b000:  cond = (op_rs1 == op_rs2);
      3'b001:  cond = (op_rs1 != op_rs2);
      3'b100:  cond = ($signed(op_rs1) < $signed(op_rs2));
      3'b101:  cond = ($signed(op_rs1) >= $signed(op_rs2));
      3'b110:  cond = (op_rs1 < op_rs2);
      3'b111:  cond = (op_rs1 >= op_rs2);
      default: cond = 1'b0;
    endcase
  end

  // A bubble has valid=0, which keeps the redirect quiet.
  assign br_taken  = idex.valid & (idex.jump | (idex.branch & cond));
  assign br_target = idex.pc + idex.imm;
  assign pc_plus4  = idex.pc + {{(XLEN-3){1'b0}}, 3'd4};

  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid      <= 1'b0;
      exm_reg_write  <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_result_src <= 2'b00;
      exm_alu_result <= '0;
      exm_write_data <= '0;
      exm_pc_plus4   <= '0;
      exm_rd         <= '0;
    end else if (!ex_hold) begin
      exm_valid      <= idex.valid;
      exm_reg_write  <= idex.reg_write;
      exm_mem_write  <= idex.mem_write;
      exm_result_src <= idex.result_src;
      exm_alu_result <= alu_y;
      exm_write_data <= op_rs2;
      exm_pc_plus4   <= pc_plus4;
      exm_rd         <= idex.rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_execute_stage: directed self-checking bench for execute_stage. Rev 1.0
// ----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        ex_hold;
  logic        id_flush;
  logic        id_valid;
  logic        id_reg_write;
  logic        id_mem_write;
  logic        id_alu_src;
  logic        id_branch;
  logic        id_jump;
  logic [3:0]  id_alu_control;
  logic [2:0]  id_funct3;
  logic [1:0]  id_result_src;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exm_valid;
  logic        exm_reg_write;
  logic        exm_mem_write;
  logic [1:0]  exm_result_src;
  logic [31:0] exm_alu_result;
  logic [31:0] exm_write_data;
  logic [31:0] exm_pc_plus4;
  logic [4:0]  exm_rd;

  int passed = 0;
  int total  = 0;

`ifdef EX_FORWARD_EN
  localparam logic [31:0] SUB_EXP   = 32'd2;
  localparam logic [31:0] MEMWB_EXP = 32'd7;
`else
  localparam logic [31:0] SUB_EXP   = 32'hFFFF_FFFF;
  localparam logic [31:0] MEMWB_EXP = 32'd1;
`endif

  execute_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_hold        (ex_hold),
    .id_flush       (id_flush),
    .id_valid       (id_valid),
    .id_reg_write   (id_reg_write),
    .id_mem_write   (id_mem_write),
    .id_alu_src     (id_alu_src),
    .id_branch      (id_branch),
    .id_jump        (id_jump),
    .id_alu_control (id_alu_control),
    .id_funct3      (id_funct3),
    .id_result_src  (id_result_src),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .exm_valid      (exm_valid),
    .exm_reg_write  (exm_reg_write),
    .exm_mem_write  (exm_mem_write),
    .exm_result_src (exm_result_src),
    .exm_alu_result (exm_alu_result),
    .exm_write_data (exm_write_data),
    .exm_pc_plus4   (exm_pc_plus4),
    .exm_rd         (exm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid       = 1'b0;
    id_reg_write   = 1'b0;
    id_mem_write   = 1'b0;
    id_alu_src     = 1'b0;
    id_branch      = 1'b0;
    id_jump        = 1'b0;
    id_alu_control = 4'b0000;
    id_funct3      = 3'b000;
    id_result_src  = 2'b00;
    id_pc          = 32'd0;
    id_rs1_data    = 32'd0;
    id_rs2_data    = 32'd0;
    id_imm         = 32'd0;
    id_rs1         = 5'd0;
    id_rs2         = 5'd0;
    id_rd          = 5'd0;
  endtask

  // Register-register or register-immediate ALU op with reg_write set.
  task automatic alu_op(input logic [3:0] code, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic src,
                        input logic [31:0] imm, input logic [4:0] rd);
    idle();
    id_valid       = 1'b1;
    id_reg_write   = 1'b1;
    id_alu_control = code;
    id_rs1         = rs1;
    id_rs1_data    = d1;
    id_rs2         = rs2;
    id_rs2_data    = d2;
    id_alu_src     = src;
    id_imm         = imm;
    id_rd          = rd;
  endtask

  initial begin
    rst = 1'b1; ex_hold = 1'b0; id_flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("reset_exm_valid", {31'd0, exm_valid}, 32'd0);
    chk("reset_exm_alu", exm_alu_result, 32'd0);
    chk("reset_br_taken", {31'd0, br_taken}, 32'd0);

    // add x3,x1,x2 then sub x4,x3,x1 back-to-back
    alu_op(4'b0000, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 5'd3);
    step();
    alu_op(4'b1000, 5'd3, 32'd0, 5'd1, 32'd1, 1'b0, 32'd0, 5'd4);
    step();
    chk("add_result", exm_alu_result, 32'd3);
    chk("add_rd", {27'd0, exm_rd}, 32'd3);
    idle();
    step();
    chk("sub_mem_fwd", exm_alu_result, SUB_EXP);
    chk("sub_write_data", exm_write_data, 32'd1);

    // MEM (7) and WB (9) both target x5
    alu_op(4'b0000, 5'd0, 32'd7, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5);
    step();
    alu_op(4'b0000, 5'd5, 32'd1, 5'd0, 32'd0, 1'b0, 32'd0, 5'd6);
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'd9;
    step();
    idle();
    step();
    chk("mem_over_wb", exm_alu_result, MEMWB_EXP);

    // x0 is never forwarded
    alu_op(4'b0000, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd7);
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'd9;
    step();
    idle();
    step();
    chk("x0_no_fwd", exm_alu_result, 32'd0);
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;

    // ALU corner cases, pipelined one per cycle
    alu_op(4'b1101, 5'd0, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd4, 5'd20);
    step();
    alu_op(4'b0101, 5'd0, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd4, 5'd21);
    step();
    chk("alu_sra", exm_alu_result, 32'hF800_0000);
    alu_op(4'b0011, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 32'd1, 5'd22);
    step();
    chk("alu_srl", exm_alu_result, 32'h0800_0000);
    alu_op(4'b0010, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 32'd1, 5'd23);
    step();
    chk("alu_sltu", exm_alu_result, 32'd0);
    alu_op(4'b1001, 5'd0, 32'd5, 5'd0, 32'd0, 1'b1, 32'd3, 5'd24);
    step();
    chk("alu_slt", exm_alu_result, 32'd1);
    alu_op(4'b0000, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 32'd1, 5'd25);
    step();
    chk("alu_undef_code", exm_alu_result, 32'd0);
    idle();
    step();
    chk("alu_add_wrap", exm_alu_result, 32'd0);

    // blt taken, bltu not taken on the same operands
    idle();
    id_valid = 1'b1; id_branch = 1'b1; id_funct3 = 3'b100;
    id_pc = 32'h100; id_imm = 32'hFFFF_FFF8;
    id_rs1 = 5'd10; id_rs1_data = 32'hFFFF_FFFF; id_rs2 = 5'd11; id_rs2_data = 32'd0;
    step();
    chk("blt_taken", {31'd0, br_taken}, 32'd1);
    chk("blt_target", br_target, 32'hF8);
    id_funct3 = 3'b110;
    step();
    chk("bltu_not_taken", {31'd0, br_taken}, 32'd0);
    idle();
    step();
    chk("bubble_no_branch", {31'd0, br_taken}, 32'd0);

    // jal with pc+4 wrapping
    idle();
    id_valid = 1'b1; id_jump = 1'b1; id_reg_write = 1'b1; id_result_src = 2'b10;
    id_pc = 32'hFFFF_FFFC; id_imm = 32'd8; id_rd = 5'd1;
    step();
    chk("jal_taken", {31'd0, br_taken}, 32'd1);
    chk("jal_target", br_target, 32'd4);
    idle();
    step();
    chk("jal_pc_plus4", exm_pc_plus4, 32'd0);
    chk("jal_result_src", {30'd0, exm_result_src}, 32'd2);

    // hold + flush freezes everything, then flush alone bubbles ID/EX
    alu_op(4'b0000, 5'd0, 32'd20, 5'd0, 32'd22, 1'b0, 32'd0, 5'd12);
    step();
    idle();
    id_valid = 1'b1; id_jump = 1'b1; id_reg_write = 1'b1; id_result_src = 2'b10;
    id_pc = 32'h200; id_imm = 32'h10; id_rd = 5'd1;
    step();
    alu_op(4'b0000, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 32'd0, 5'd13);
    ex_hold = 1'b1; id_flush = 1'b1;
    step();
    step();
    chk("hold_exm_alu", exm_alu_result, 32'd42);
    chk("hold_exm_rd", {27'd0, exm_rd}, 32'd12);
    chk("hold_br_taken", {31'd0, br_taken}, 32'd1);
    chk("hold_br_target", br_target, 32'h210);
    ex_hold = 1'b0;
    step();
    chk("flush_br_taken", {31'd0, br_taken}, 32'd0);
    chk("flush_exm_valid", {31'd0, exm_valid}, 32'd1);
    chk("flush_exm_pc4", exm_pc_plus4, 32'h204);
    id_flush = 1'b0;
    idle();
    step();
    chk("bubble_exm_valid", {31'd0, exm_valid}, 32'd0);
    chk("bubble_exm_regw", {31'd0, exm_reg_write}, 32'd0);

    // reset mid-stream with id_valid held high
    alu_op(4'b0000, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 32'd0, 5'd14);
    id_jump = 1'b1; id_pc = 32'h40; id_mem_write = 1'b1;
    step();
    chk("pre_rst_taken", {31'd0, br_taken}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_exm_valid", {31'd0, exm_valid}, 32'd0);
    chk("rst_exm_regw", {31'd0, exm_reg_write}, 32'd0);
    chk("rst_exm_memw", {31'd0, exm_mem_write}, 32'd0);
    chk("rst_exm_alu", exm_alu_result, 32'd0);
    chk("rst_exm_rd", {27'd0, exm_rd}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    chk("rst2_exm_pc4", exm_pc_plus4, 32'd0);
    chk("rst2_exm_wdata", exm_write_data, 32'd0);
    chk("rst2_br_taken", {31'd0, br_taken}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
